// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master state encoding and frame width
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_master_clkdiv.sv
// rtl/spi_master_clkdiv.sv - SCK half-period tick counter with synchronous clear
module spi_master_clkdiv #(
    parameter int TICKS_PER_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(TICKS_PER_HALF - 1);

    logic [7:0] cnt;

    // Held clear means no tick, so IDLE/WAIT never see a stray half-period end.
    assign tick = (cnt == LAST) && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master; SPI_MASTER_LOOPBACK_EN samples spi_sdo instead of spi_sdi
module spi_master
    import spi_pkg::*;
#(
    parameter int TICKS_PER_HALF = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_last,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                spi_sck,
    output logic                spi_csn,
    output logic                spi_sdo,
    input  logic                spi_sdi
);

    localparam logic [3:0] HALF_LAST = 4'(2 * SPI_BITS - 1);
    localparam logic [3:0] FALL_LAST = 4'(2 * SPI_BITS - 2);

    spi_state_e          state;
    logic [SPI_BITS-1:0] tx_sh;
    logic [SPI_BITS-1:0] rx_sh;
    logic [3:0]          half;
    logic                last_q;
    logic                tick;
    logic                div_clr;
    logic                rx_bit;

    assign div_clr = (state == IDLE) || (state == WAIT);

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_sdi;
    assign unused_sdi = spi_sdi;
    assign rx_bit     = spi_sdo;
`else
    assign rx_bit     = spi_sdi;
`endif

    spi_master_clkdiv #(
        .TICKS_PER_HALF(TICKS_PER_HALF)
    ) u_clkdiv (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            spi_csn  <= 1'b1;
            spi_sck  <= 1'b0;
            spi_sdo  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            half     <= '0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    if (tx_valid && tx_ready) begin
                        state    <= SETUP;
                        tx_ready <= 1'b0;
                        spi_csn  <= 1'b0;
                        spi_sdo  <= tx_data[SPI_BITS-1];
                        tx_sh    <= tx_data;
                        last_q   <= tx_last;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state   <= SHIFT;
                        spi_sck <= 1'b1;
                        half    <= '0;
                        rx_sh   <= {rx_sh[SPI_BITS-2:0], rx_bit};
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (half == HALF_LAST) begin
                            state    <= last_q ? HOLD : WAIT;
                            tx_ready <= !last_q;
                        end else begin
                            half    <= half + 4'd1;
                            spi_sck <= ~spi_sck;
                            // sck high now means this tick is a falling edge
                            if (spi_sck) begin
                                if (half == FALL_LAST) begin
                                    rx_data  <= rx_sh;
                                    rx_valid <= 1'b1;
                                end else begin
                                    spi_sdo <= tx_sh[SPI_BITS-2];
                                    tx_sh   <= tx_sh << 1;
                                end
                            end else begin
                                rx_sh <= {rx_sh[SPI_BITS-2:0], rx_bit};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state   <= GAP;
                        spi_csn <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter TICKS_PER_HALF, default 4: clk cycles per SCK half-period; legal values are 1 to 255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tx_data, input, 8 bits: the byte to shift out, MSB first.
REQ-005 SHALL have port tx_last, input, 1 bit: set when this byte ends the transaction (CSN is released afterwards).
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data and tx_last are valid.
REQ-007 SHALL have port tx_ready, output, 1 bit: a byte can be accepted.
REQ-008 SHALL have port rx_data, output, 8 bits: the byte received during the last completed byte.
REQ-009 SHALL have port rx_valid, output, 1 bit: a one-cycle pulse marking a new rx_data.
REQ-010 SHALL have the SPI pins spi_sck (output, 1), spi_csn (output, 1, active low), spi_sdo (output, 1, controller to peripheral) and spi_sdi (input, 1, peripheral to controller).

Function
REQ-011 SHALL implement SPI mode 0: SCK idles low, spi_sdi is sampled on each SCK rising edge, and spi_sdo changes only while SCK is low.
REQ-012 SHALL accept a byte only on a cycle where tx_valid and tx_ready are both high; tx_data and tx_last are latched on that cycle.
REQ-013 SHALL use the FSM states IDLE, SETUP, SHIFT, WAIT, HOLD and GAP; all outputs are registered.
REQ-014 SHALL drive tx_ready high only in IDLE and WAIT.
REQ-015 SHALL, on accept in IDLE, go to SETUP on the next cycle with spi_csn=0, spi_sck=0 and spi_sdo=bit 7, and stay in SETUP for TICKS_PER_HALF cycles.
REQ-016 SHALL, in SHIFT, toggle SCK every TICKS_PER_HALF cycles for 16 half-periods (8 rising, 8 falling) and shift the next bit onto spi_sdo at each falling edge except the 8th.
REQ-017 SHALL, on the 8th falling edge, update rx_data and pulse rx_valid high for exactly one cycle.
REQ-018 SHALL then go to HOLD if the latched tx_last=1, otherwise to WAIT.
REQ-019 SHALL, in WAIT, keep spi_csn low and SCK low, and on accept go to SETUP with the new bit 7 on spi_sdo.
REQ-020 SHALL, in HOLD, keep spi_csn low for TICKS_PER_HALF cycles, then drive spi_csn high and enter GAP.
REQ-021 SHALL, in GAP, keep spi_csn high for TICKS_PER_HALF cycles and then return to IDLE; a single-byte last transaction therefore holds CSN low for (18*TICKS_PER_HALF) cycles.
REQ-022 SHALL ignore tx_valid while tx_ready is low; stimulus arriving during GAP waits for IDLE.
REQ-023 SHALL keep rx_data stable between rx_valid pulses; no backpressure exists on rx, so a missed pulse loses that byte.
REQ-024 SHALL, with TICKS_PER_HALF=1, toggle SCK every cycle with no dropped edges.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, spi_csn=1, spi_sck=0, spi_sdo=0, tx_ready=0, rx_valid=0, rx_data=8'h00 and the tick counter=0.
REQ-026 SHALL, when rst is asserted mid-transaction, abort immediately, raising CSN on the next edge with no HOLD and emitting no rx_valid.
REQ-027 SHALL raise tx_ready the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, when SPI_MASTER_LOOPBACK_EN is defined, sample the internal spi_sdo instead of spi_sdi, leaving spi_sdi unused.
REQ-029 SHALL, when SPI_MASTER_LOOPBACK_EN is undefined, sample spi_sdi; pin timing is identical in both builds.

Structure
REQ-030 SHALL take the FSM state enum and the SPI_BITS=8 constant from the shared package spi_pkg.
REQ-031 SHALL use one sub-module, spi_master_clkdiv: a half-period tick counter with a synchronous clear, reset in IDLE, WAIT and on rst.

Verification
REQ-032 SHALL check: TICKS_PER_HALF=2, send 8'hA5 with last=1, peripheral model returns 8'h3C -> spi_sdo bits 1,0,1,0,0,1,0,1 are stable at each rising edge, rx_data=8'h3C with a single rx_valid, and CSN is low for 36 cycles.
REQ-033 SHALL check: send 8'h01 (last=0) then 8'hFF (last=1) -> CSN stays low across both bytes, there are 16 rising edges total, and there are two rx_valid pulses.
REQ-034 SHALL check: WAIT is held 10 cycles with tx_valid=0 -> CSN stays low, SCK stays low, tx_ready=1.
REQ-035 SHALL check: rst is asserted after the 3rd rising edge -> CSN=1 and SCK=0 one cycle later, no rx_valid, and tx_ready=1 after release.
REQ-036 SHALL check: the SPI_MASTER_LOOPBACK_EN build with TICKS_PER_HALF=1, sending 8'h5A -> rx_data=8'h5A.
REQ-037 SHALL check: tx_valid is held high during GAP -> no accept before IDLE, and CSN is high for at least TICKS_PER_HALF cycles.
